// File: rtl/ir_key_decoder.sv
// ir_key_decoder: validates NEC frames, filters address, suppresses held-key repeats, queues keys.
module ir_key_decoder #(
  parameter int          CLK_MHZ    = 50,
  parameter bit          ADDR_CHECK = 1'b1,
  parameter logic [7:0]  IR_ADDRESS = 8'h00,
  parameter int          HOLDOFF_MS = 200,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IR_DATA,
  input  logic        IR_DATA_READY,
  input  logic [7:0]  IR_ERROR_CODE,
  output logic        KEY_VALID,
  output logic [7:0]  KEY_CODE,
  input  logic        KEY_READY,
  output logic        OVERFLOW,
  output logic [7:0]  ERR_COUNT
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int PRE_N = CLK_MHZ * 1000;
  localparam int SW = $clog2(PRE_N);
  localparam logic [SW-1:0] PRE_MAX = SW'(PRE_N - 1);
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);
  logic [31:0] frame_q;
  logic [7:0] err_q;
  logic chk_v_q;
  logic [SW-1:0] pre_q, pre_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0] last_q, last_d, err_cnt_q, err_cnt_d;
  logic [PW:0] wr_q, wr_d, rd_q, rd_d;
  logic ovf_q, ovf_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [7:0] cmd;
  logic tick, reject, repeat_hit, push, pop, full, empty, wr_en;
  always_comb begin
    cmd = frame_q[15:8];
    reject = err_q != 8'd0 || cmd != ~frame_q[7:0] ||
             (ADDR_CHECK && (frame_q[31:24] != ~frame_q[23:16] || frame_q[31:24] != IR_ADDRESS));
    repeat_hit = cmd == last_q && timer_q != 16'd0;
    push = chk_v_q && !reject && !repeat_hit;
    empty = wr_q == rd_q;
    full = wr_q[PW] != rd_q[PW] && wr_q[PW-1:0] == rd_q[PW-1:0];
    pop = !empty && KEY_READY;
    wr_en = push && (!full || pop);
    tick = pre_q == PRE_MAX;
    pre_d = tick ? '0 : pre_q + SW'(1);
    // Any valid frame (accepted or repeat) restarts the holdoff window; reload beats a tick.
    timer_d = (chk_v_q && !reject) ? 16'(HOLDOFF_MS) :
              (tick && timer_q != 16'd0) ? timer_q - 16'd1 : timer_q;
    last_d = push ? cmd : last_q;
    err_cnt_d = (chk_v_q && reject && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    wr_d = wr_en ? wr_q + PTR_ONE : wr_q;
    rd_d = pop ? rd_q + PTR_ONE : rd_q;
    ovf_d = ovf_q || (push && full && !pop);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      chk_v_q <= 1'b0;
      pre_q <= '0;
      timer_q <= '0;
      last_q <= '0;
      err_cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      chk_v_q <= IR_DATA_READY;
      pre_q <= pre_d;
      timer_q <= timer_d;
      last_q <= last_d;
      err_cnt_q <= err_cnt_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (IR_DATA_READY) begin
      frame_q <= IR_DATA;
      err_q <= IR_ERROR_CODE;
    end
  end
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_q[PW-1:0]] <= cmd;
  end
  assign KEY_VALID = !empty;
  assign KEY_CODE = empty ? 8'd0 : mem_q[rd_q[PW-1:0]];
  assign OVERFLOW = ovf_q;
  assign ERR_COUNT = err_cnt_q;
endmodule
